// File: rtl/excep_arbiter.sv
// rtl/excep_arbiter.sv - MEM-stage exception/interrupt arbiter and CP0 commit sequencer
// Picks one event by fixed priority, waits out data-SRAM traffic, commits to CP0, then flushes and redirects IF.
module excep_arbiter #(
   parameter logic [31:0] EXCEP_VECTOR = 32'hBFC0_0380,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] excep_type_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] mem_addr_i,
   input  logic        in_delayslot_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        mem_busy_i,
   input  logic        if_ready_i,
   output logic        commit_o,
   output logic        eret_o,
   output logic [4:0]  excep_code_o,
   output logic [31:0] epc_o,
   output logic        bd_o,
   output logic [31:0] badvaddr_o,
   output logic        badvaddr_we_o,
   output logic        flush_o,
   output logic        stall_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o
);

   typedef enum logic [1:0] {IDLE, WAIT_MEM, FLUSH, REDIRECT} state_t;

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES);

   state_t      state;
   logic [2:0]  flush_cnt;

   logic        cap_eret;
   logic [4:0]  cap_code;
   logic [31:0] cap_epc;
   logic        cap_bd;
   logic [31:0] cap_badvaddr;
   logic        cap_bv_we;
   logic [31:0] cap_target;

   logic        int_pend;
   logic        ev_valid;
   logic        ev_eret;
   logic [4:0]  ev_code;
   logic [31:0] ev_badvaddr;
   logic        ev_bv_we;
   logic [31:0] ev_epc;
   logic [31:0] ev_target;

   logic        unused_bits;
   assign unused_bits = ^{excep_type_i[24:1], status_i[31:16], status_i[7:2],
                          cause_i[31:16], cause_i[7:0]};

   assign int_pend = (|(cause_i[15:8] & status_i[15:8])) & status_i[0] & ~status_i[1];
   assign ev_epc   = in_delayslot_i ? (pc_i - 32'd4) : pc_i;

   always_comb begin
      ev_valid    = 1'b1;
      ev_eret     = 1'b0;
      ev_code     = 5'd0;
      ev_badvaddr = 32'd0;
      ev_bv_we    = 1'b0;
      if (int_pend) begin
         ev_code = 5'd0;
      end else if (excep_type_i[31]) begin
         ev_code     = 5'd4;
         ev_badvaddr = pc_i;
         ev_bv_we    = 1'b1;
      end else if (excep_type_i[30]) begin
         ev_code = 5'd10;
      end else if (excep_type_i[29]) begin
         ev_code = 5'd12;
      end else if (excep_type_i[28]) begin
         ev_code = 5'd9;
      end else if (excep_type_i[27]) begin
         ev_code = 5'd8;
      end else if (excep_type_i[26]) begin
         ev_code     = 5'd4;
         ev_badvaddr = mem_addr_i;
         ev_bv_we    = 1'b1;
      end else if (excep_type_i[25]) begin
         ev_code     = 5'd5;
         ev_badvaddr = mem_addr_i;
         ev_bv_we    = 1'b1;
      end else if (excep_type_i[0]) begin
         ev_eret = 1'b1;
      end else begin
         ev_valid = 1'b0;
      end
   end

   assign ev_target = ev_eret ? epc_i : EXCEP_VECTOR;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         flush_cnt        <= 3'd0;
         cap_eret         <= 1'b0;
         cap_code         <= 5'd0;
         cap_epc          <= 32'd0;
         cap_bd           <= 1'b0;
         cap_badvaddr     <= 32'd0;
         cap_bv_we        <= 1'b0;
         cap_target       <= 32'd0;
         commit_o         <= 1'b0;
         eret_o           <= 1'b0;
         excep_code_o     <= 5'd0;
         epc_o            <= 32'd0;
         bd_o             <= 1'b0;
         badvaddr_o       <= 32'd0;
         badvaddr_we_o    <= 1'b0;
         flush_o          <= 1'b0;
         stall_o          <= 1'b0;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= 32'd0;
      end else begin
         // Commit fields are a one-cycle pulse; zero them unless re-asserted below.
         commit_o      <= 1'b0;
         eret_o        <= 1'b0;
         excep_code_o  <= 5'd0;
         epc_o         <= 32'd0;
         bd_o          <= 1'b0;
         badvaddr_o    <= 32'd0;
         badvaddr_we_o <= 1'b0;
         case (state)
            IDLE: begin
               if (ev_valid) begin
                  cap_eret     <= ev_eret;
                  cap_code     <= ev_code;
                  cap_epc      <= ev_epc;
                  cap_bd       <= in_delayslot_i;
                  cap_badvaddr <= ev_badvaddr;
                  cap_bv_we    <= ev_bv_we;
                  cap_target   <= ev_target;
                  stall_o      <= 1'b1;
                  if (mem_busy_i) begin
                     state <= WAIT_MEM;
                  end else begin
                     state         <= FLUSH;
                     flush_o       <= 1'b1;
                     flush_cnt     <= 3'd1;
                     commit_o      <= 1'b1;
                     eret_o        <= ev_eret;
                     excep_code_o  <= ev_code;
                     epc_o         <= ev_epc;
                     bd_o          <= in_delayslot_i;
                     badvaddr_o    <= ev_badvaddr;
                     badvaddr_we_o <= ev_bv_we;
                  end
               end
            end
            WAIT_MEM: begin
               if (!mem_busy_i) begin
                  state         <= FLUSH;
                  flush_o       <= 1'b1;
                  flush_cnt     <= 3'd1;
                  commit_o      <= 1'b1;
                  eret_o        <= cap_eret;
                  excep_code_o  <= cap_code;
                  epc_o         <= cap_epc;
                  bd_o          <= cap_bd;
                  badvaddr_o    <= cap_badvaddr;
                  badvaddr_we_o <= cap_bv_we;
               end
            end
            FLUSH: begin
               if (flush_cnt == FLUSH_LAST) begin
                  state            <= REDIRECT;
                  flush_o          <= 1'b0;
                  flush_cnt        <= 3'd0;
                  redirect_valid_o <= 1'b1;
                  redirect_pc_o    <= cap_target;
               end else begin
                  flush_cnt <= flush_cnt + 3'd1;
               end
            end
            REDIRECT: begin
               if (if_ready_i) begin
                  state            <= IDLE;
                  stall_o          <= 1'b0;
                  redirect_valid_o <= 1'b0;
                  redirect_pc_o    <= 32'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
